// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line scheduler.
// Attribute word layout, sprite size, scheduler state encoding.
package sprite_pkg;

    localparam int SPRITE_W = 16;
    localparam int SPRITE_H = 16;

    localparam int ATTR_X_LSB     = 0;
    localparam int ATTR_Y_LSB     = 10;
    localparam int ATTR_FRAME_LSB = 20;
    localparam int ATTR_FLIP_BIT  = 28;
    localparam int ATTR_VIS_BIT   = 29;
    localparam int ATTR_W         = 30;

    typedef struct packed {
        logic       visible;
        logic       flip;
        logic [7:0] frame_id;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } sched_state_e;

    function automatic sprite_attr_t attr_unpack(
        input logic [ATTR_W-1:0] w
    );
        sprite_attr_t a;
        a.x        = w[ATTR_X_LSB +: 10];
        a.y        = w[ATTR_Y_LSB +: 10];
        a.frame_id = w[ATTR_FRAME_LSB +: 8];
        a.flip     = w[ATTR_FLIP_BIT];
        a.visible  = w[ATTR_VIS_BIT];
        return a;
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Draw-command bus between the scheduler and sprite_drawer.
// master: scheduler (drives drw_*), slave: drawer (drives drw_done).
interface sprite_line_scheduler_if;

    logic       drw_start;
    logic [9:0] drw_col_base;
    logic       drw_flip;
    logic [7:0] drw_frame_id;
    logic [3:0] drw_row_off;
    logic       drw_done;

    modport master (
        output drw_start,
        output drw_col_base,
        output drw_flip,
        output drw_frame_id,
        output drw_row_off,
        input  drw_done
    );

    modport slave (
        input  drw_start,
        input  drw_col_base,
        input  drw_flip,
        input  drw_frame_id,
        input  drw_row_off,
        output drw_done
    );

endinterface

// File: rtl/sprite_attr_table.sv
// Sprite attribute storage: CPU write port, combinational read by index.
// Ports: clk, reset, wr_en/wr_addr/wr_data (CPU), vsync, rd_idx -> rd_attr.
// SPRITE_SHADOW_EN: writes land in a shadow table copied to active on vsync.
module sprite_attr_table
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 32,
    parameter int AW          = $clog2(NUM_SPRITES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          vsync,
    input  logic [AW-1:0] rd_idx,
    output sprite_attr_t  rd_attr
);

    sprite_attr_t active_q [NUM_SPRITES];

    logic unused_hi;
    assign unused_hi = ^wr_data[31:ATTR_W];

`ifdef SPRITE_SHADOW_EN
    sprite_attr_t shadow_q [NUM_SPRITES];

    // Copy and write share an edge, so the copy sees pre-write shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_q[i] <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            if (vsync) active_q <= shadow_q;
            if (wr_en) shadow_q[wr_addr] <= attr_unpack(wr_data[ATTR_W-1:0]);
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) active_q[i] <= '0;
        end else if (wr_en) begin
            active_q[wr_addr] <= attr_unpack(wr_data[ATTR_W-1:0]);
        end
    end
`endif

    assign rd_attr = active_q[rd_idx];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table in index order
// and issues one draw command per intersecting sprite, waiting on drw_done.
// Ports: clk/reset, attr_* (CPU write), vsync, line_start/line_y,
//   drw (draw bus, master), line_busy/line_done, overflow_flag/late_flag.
// Optional SPRITE_SHADOW_EN macro enables double-buffered attributes.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 32,
    parameter int MAX_PER_LINE = 16,
    parameter int AW           = $clog2(NUM_SPRITES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     attr_write,
    input  logic [AW-1:0]            attr_addr,
    input  logic [31:0]              attr_writedata,
    input  logic                     vsync,
    input  logic                     line_start,
    input  logic [9:0]               line_y,
    sprite_line_scheduler_if.master  drw,
    output logic                     line_busy,
    output logic                     line_done,
    output logic                     overflow_flag,
    output logic                     late_flag
);

    localparam int HW = $clog2(MAX_PER_LINE + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);
    localparam logic [HW-1:0] HIT_MAX  = HW'(MAX_PER_LINE);

    sched_state_e  state_q;
    logic [AW-1:0] idx_q;
    logic [HW-1:0] hits_q;
    logic [9:0]    line_y_q;
    logic          wait_first_q;
    logic          restart_q;

    sprite_attr_t  ent;
    logic [10:0]   diff;
    logic          hit;

    sprite_attr_table #(
        .NUM_SPRITES (NUM_SPRITES),
        .AW          (AW)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (attr_write),
        .wr_addr (attr_addr),
        .wr_data (attr_writedata),
        .vsync   (vsync),
        .rd_idx  (idx_q),
        .rd_attr (ent)
    );

    assign diff = {1'b0, line_y_q} - {1'b0, ent.y};
    assign hit  = ent.visible && (line_y_q >= ent.y)
               && (diff < 11'(SPRITE_H));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            idx_q             <= '0;
            hits_q            <= '0;
            line_y_q          <= '0;
            wait_first_q      <= 1'b0;
            restart_q         <= 1'b0;
            drw.drw_start     <= 1'b0;
            drw.drw_col_base  <= '0;
            drw.drw_flip      <= 1'b0;
            drw.drw_frame_id  <= '0;
            drw.drw_row_off   <= '0;
            line_busy         <= 1'b0;
            line_done         <= 1'b0;
            overflow_flag     <= 1'b0;
            late_flag         <= 1'b0;
        end else begin
            drw.drw_start <= 1'b0;
            line_done     <= 1'b0;
            if (vsync) begin
                overflow_flag <= 1'b0;
                late_flag     <= 1'b0;
            end
            if (line_start && state_q != S_IDLE) begin
                // Restart; a command already on the bus must still complete
                // before the new line may issue, so park in WAIT.
                late_flag <= 1'b1;
                line_y_q  <= line_y;
                idx_q     <= '0;
                hits_q    <= '0;
                line_busy <= 1'b1;
                if (state_q == S_ISSUE) begin
                    state_q      <= S_WAIT;
                    wait_first_q <= 1'b1;
                    restart_q    <= 1'b1;
                end else if (state_q == S_WAIT) begin
                    restart_q    <= 1'b1;
                end else begin
                    state_q      <= S_CHECK;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (line_start) begin
                            line_y_q  <= line_y;
                            idx_q     <= '0;
                            hits_q    <= '0;
                            line_busy <= 1'b1;
                            state_q   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (hit && hits_q != HIT_MAX) begin
                            drw.drw_start    <= 1'b1;
                            drw.drw_col_base <= ent.x;
                            drw.drw_flip     <= ent.flip;
                            drw.drw_frame_id <= ent.frame_id;
                            drw.drw_row_off  <= diff[3:0];
                            state_q          <= S_ISSUE;
                        end else if (hit) begin
                            overflow_flag <= 1'b1;
                            line_done     <= 1'b1;
                            state_q       <= S_FINISH;
                        end else if (idx_q == LAST_IDX) begin
                            line_done <= 1'b1;
                            state_q   <= S_FINISH;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        hits_q       <= hits_q + 1'b1;
                        wait_first_q <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                    S_WAIT: begin
                        // drw_done may still show the idle level in the
                        // first cycle, before the drawer reacts.
                        if (wait_first_q) begin
                            wait_first_q <= 1'b0;
                        end else if (drw.drw_done) begin
                            if (restart_q) begin
                                restart_q <= 1'b0;
                                state_q   <= S_CHECK;
                            end else if (idx_q == LAST_IDX) begin
                                line_done <= 1'b1;
                                state_q   <= S_FINISH;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= S_CHECK;
                            end
                        end
                    end
                    S_FINISH: begin
                        line_busy <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler with a stub drawer.
// Reference model: attribute arrays plus a per-line command queue.
module tb_sprite_line_scheduler;

    localparam int NS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        attr_write = 1'b0;
    logic [4:0]  attr_addr = '0;
    logic [31:0] attr_writedata = '0;
    logic        vsync = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0;
    logic        line_busy, line_done, overflow_flag, late_flag;

    sprite_line_scheduler_if drw();

    sprite_line_scheduler #(
        .NUM_SPRITES  (NS),
        .MAX_PER_LINE (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .attr_write     (attr_write),
        .attr_addr      (attr_addr),
        .attr_writedata (attr_writedata),
        .vsync          (vsync),
        .line_start     (line_start),
        .line_y         (line_y),
        .drw            (drw),
        .line_busy      (line_busy),
        .line_done      (line_done),
        .overflow_flag  (overflow_flag),
        .late_flag      (late_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub drawer: busy for 16 cycles after each command.
    int dcnt = 0;
    always @(posedge clk) begin
        if (reset) dcnt <= 0;
        else if (drw.drw_start) dcnt <= 16;
        else if (dcnt > 0) dcnt <= dcnt - 1;
    end
    assign drw.drw_done = (dcnt == 0);

    typedef struct {
        int x; int y; int fr; int fl; int vis;
    } m_attr_t;

    m_attr_t     act [NS];
    m_attr_t     shd [NS];
    logic [22:0] exp_q [$];
    logic [22:0] hold_cmd = '0;
    int          seen_cols [$];
    int          checks = 0, failures = 0;
    int          n_starts = 0, n_done = 0;
    int          ls_cyc = 0, done_cyc = 0;

    logic [22:0] dut_cmd;
    assign dut_cmd = {drw.drw_col_base, drw.drw_flip,
                      drw.drw_frame_id, drw.drw_row_off};

    function automatic logic [22:0] pack_cmd(int col, int fl, int fr, int row);
        return {10'(col), 1'(fl), 8'(fr), 4'(row)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    // Commands a line must produce: every visible sprite whose 16-row
    // span covers ly, in index order, at most 16.
    function automatic void build_expect(int ly);
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            if (act[i].vis != 0 && ly >= act[i].y && ly - act[i].y < 16) begin
                if (exp_q.size() == 16) break;
                exp_q.push_back(pack_cmd(act[i].x, act[i].fl,
                                         act[i].fr, ly - act[i].y));
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (line_start) ls_cyc = cyc;
            if (drw.drw_start) begin
                n_starts++;
                seen_cols.push_back(int'(drw.drw_col_base));
                chk("drawer_idle_at_issue", 32'(dcnt), 0);
                chk("cmd_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("drw_cmd", 32'(dut_cmd), 32'(exp_q[0]));
                    hold_cmd = exp_q.pop_front();
                end
            end else begin
                chk("drw_hold", 32'(dut_cmd), 32'(hold_cmd));
            end
            if (line_done) begin
                n_done++;
                done_cyc = cyc;
                chk("cmds_left_at_done", 32'(exp_q.size()), 0);
            end
        end
    end

    task automatic write_attr(input int i, input int x, input int y,
                              input int fr, input int fl, input int vis);
        m_attr_t a;
        a = '{x: x, y: y, fr: fr, fl: fl, vis: vis};
        @(posedge clk); #1;
        attr_write     = 1'b1;
        attr_addr      = 5'(i);
        attr_writedata = {2'b11, 1'(vis), 1'(fl), 8'(fr), 10'(y), 10'(x)};
        @(posedge clk); #1;
        attr_write = 1'b0;
`ifdef SPRITE_SHADOW_EN
        shd[i] = a;
`else
        act[i] = a;
`endif
    endtask

    task automatic do_vsync();
        @(posedge clk); #1;
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
`ifdef SPRITE_SHADOW_EN
        act = shd;
`endif
    endtask

    task automatic start_line(input int y);
        build_expect(y);
        seen_cols.delete();
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y     = 10'(y);
        @(posedge clk); #1;
        line_start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(line_busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int k;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("line_done_seen", 32'(n_done != n0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_line(input int y);
        start_line(y);
        wait_done(3000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int d0;
        int k;
        int cols4 [4];
        cols4 = '{10, 20, 30, 40};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_drw_start", 32'(drw.drw_start), 0);
        chk("rst_drw_fields", 32'(dut_cmd), 0);
        chk("rst_line_busy", 32'(line_busy), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_overflow", 32'(overflow_flag), 0);
        chk("rst_late", 32'(late_flag), 0);

        // Empty table: nothing issued, line completes in 33 cycles.
        s0 = n_starts;
        run_line(20);
        chk("empty_starts", 32'(n_starts - s0), 0);
        chk("empty_latency", 32'(done_cyc - ls_cyc), 33);

        // Single sprite hit.
        write_attr(3, 100, 50, 7, 1, 1);
        do_vsync();
        s0 = n_starts;
        run_line(53);
        chk("one_starts", 32'(n_starts - s0), 1);
        chk("one_col", 32'(drw.drw_col_base), 100);
        chk("one_flip", 32'(drw.drw_flip), 1);
        chk("one_frame", 32'(drw.drw_frame_id), 7);
        chk("one_row", 32'(drw.drw_row_off), 3);
        chk("one_idle_busy", 32'(line_busy), 0);

        // Boundaries of the 16-row span.
        s0 = n_starts;
        run_line(49);
        chk("above_starts", 32'(n_starts - s0), 0);
        chk("above_latency", 32'(done_cyc - ls_cyc), 33);
        run_line(66);
        chk("below_starts", 32'(n_starts - s0), 0);
        chk("below_latency", 32'(done_cyc - ls_cyc), 33);
        run_line(65);
        chk("last_row_starts", 32'(n_starts - s0), 1);
        chk("last_row_off", 32'(drw.drw_row_off), 15);

        // Several hits, including the last index.
        write_attr(0, 10, 100, 1, 0, 1);
        write_attr(5, 20, 95, 2, 1, 1);
        write_attr(9, 30, 105, 3, 0, 1);
        write_attr(31, 40, 100, 4, 1, 1);
        do_vsync();
        run_line(105);
        chk("multi_count", 32'(seen_cols.size()), 4);
        for (int i = 0; i < 4 && i < seen_cols.size(); i++)
            chk("multi_order", 32'(seen_cols[i]), 32'(cols4[i]));

        // Overflow: 20 hits, 16 issued.
        for (int i = 10; i < 30; i++)
            write_attr(i, i, 200, i, i & 1, 1);
        do_vsync();
        run_line(205);
        chk("ovf_count", 32'(seen_cols.size()), 16);
        if (seen_cols.size() == 16)
            chk("ovf_last_col", 32'(seen_cols[15]), 25);
        chk("ovf_flag_set", 32'(overflow_flag), 1);
        do_vsync();
        chk("ovf_flag_clr", 32'(overflow_flag), 0);

        // Late line_start during WAIT.
        s0 = n_starts;
        start_line(205);
        k = 0;
        while (n_starts == s0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("abort_first_issue", 32'(n_starts != s0), 1);
        repeat (3) @(posedge clk);
        d0 = n_done;
        start_line(105);
        wait_done(3000);
        chk("abort_done_count", 32'(n_done - d0), 1);
        chk("abort_late_set", 32'(late_flag), 1);
        chk("abort_no_ovf", 32'(overflow_flag), 0);
        chk("abort_count", 32'(seen_cols.size()), 4);
        for (int i = 0; i < 4 && i < seen_cols.size(); i++)
            chk("abort_order", 32'(seen_cols[i]), 32'(cols4[i]));
        do_vsync();
        chk("late_clr", 32'(late_flag), 0);

        // Mid-frame attribute write.
        write_attr(3, 200, 50, 7, 1, 1);
        run_line(53);
`ifdef SPRITE_SHADOW_EN
        chk("midframe_col", 32'(drw.drw_col_base), 100);
`else
        chk("midframe_col", 32'(drw.drw_col_base), 200);
`endif
        do_vsync();
        run_line(53);
        chk("post_vsync_col", 32'(drw.drw_col_base), 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
